// File: rtl/serial_addsub_unit.sv
// serial_addsub_unit: multi-cycle add/subtract unit that processes CHUNK bits
// per clock, LSB chunk first, carrying between chunks in a register.
//
// Ports:
//   clk    - rising-edge clock
//   rst_n  - synchronous active-low reset
//   start  - operation request, honoured only in IDLE or DONE
//   a, b   - WIDTH-bit operands, latched on an accepted start
//   sub    - 0: a+b+cin, 1: a-b-cin (latched on start)
//   cin    - carry/borrow in (latched on start)
//   E      - output enable, combinational gate on s only
//   busy   - operation in progress
//   done   - one-cycle pulse, result and flags valid
//   s      - result AND E (combinational gate of the result register)
//   cout   - carry out of MSB (subtract: 1 = no borrow)
//   ovf    - signed overflow
//   zero   - ungated result == 0
module serial_addsub_unit #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    input  logic             E,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned N  = WIDTH / CHUNK;
    localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;

    // Operands must split into whole chunks.
    generate
        if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
            $error("serial_addsub_unit: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_accept;
    logic               w_last;

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;        // already inverted when subtracting
    logic               r_carry;
    logic [KW-1:0]      r_k;
    logic [WIDTH-1:0]   r_result;
    logic               r_busy;
    logic               r_done;
    logic               r_cout;
    logic               r_ovf;
    logic               r_zero;

    logic [CHUNK-1:0]   w_a_ch;
    logic [CHUNK-1:0]   w_b_ch;
    logic [CHUNK:0]     w_sum_ext;
    logic               w_msb_cin;
    logic [WIDTH-1:0]   w_result_nxt;

    assign w_last = (r_k == KW'(N - 1));

    // Next-state logic; start is only looked at in IDLE and DONE.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                    w_accept    = 1'b1;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                    w_accept    = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Chunk select, chunk add and merge of the new chunk into the result.
    always_comb begin
        w_a_ch       = '0;
        w_b_ch       = '0;
        w_result_nxt = r_result;
        for (int unsigned j = 0; j < N; j++) begin
            if (r_k == KW'(j)) begin
                w_a_ch = r_a[j*CHUNK +: CHUNK];
                w_b_ch = r_b[j*CHUNK +: CHUNK];
            end
        end
        w_sum_ext = {1'b0, w_a_ch} + {1'b0, w_b_ch} + (CHUNK+1)'(r_carry);
        for (int unsigned j = 0; j < N; j++) begin
            if (r_k == KW'(j)) begin
                w_result_nxt[j*CHUNK +: CHUNK] = w_sum_ext[CHUNK-1:0];
            end
        end
    end

    // Carry into the chunk MSB, recovered from the MSB sum bit.
    assign w_msb_cin = w_a_ch[CHUNK-1] ^ w_b_ch[CHUNK-1] ^ w_sum_ext[CHUNK-1];

    // State register and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_carry  <= 1'b0;
            r_k      <= '0;
            r_result <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
            r_zero   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == S_RUN);
            r_done  <= (w_state_nxt == S_DONE);
            if (w_accept) begin
                // Subtract as a + ~b + 1; borrow-in flips the injected carry.
                r_a     <= a;
                r_b     <= b ^ {WIDTH{sub}};
                r_carry <= cin ^ sub;
                r_k     <= '0;
            end else if (r_state == S_RUN) begin
                r_result <= w_result_nxt;
                r_carry  <= w_sum_ext[CHUNK];
                r_k      <= r_k + KW'(1);
                if (w_last) begin
                    r_cout <= w_sum_ext[CHUNK];
                    r_ovf  <= w_msb_cin ^ w_sum_ext[CHUNK];
                    r_zero <= (w_result_nxt == '0);
                end
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign cout = r_cout;
    assign ovf  = r_ovf;
    assign zero = r_zero;
    assign s    = r_result & {WIDTH{E}};

endmodule

// File: tb/tb_serial_addsub_unit.sv
// Self-checking bench for serial_addsub_unit (WIDTH=16, CHUNK=4 and CHUNK=16).
module tb_serial_addsub_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        start2;
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic        cin;
    logic        E;
    logic        busy, done, cout, ovf, zero;
    logic [15:0] s;
    logic        busy2, done2, cout2, ovf2, zero2;
    logic [15:0] s2;

    always #5 clk = ~clk;

    serial_addsub_unit #(.WIDTH(16), .CHUNK(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .sub(sub),
        .cin(cin), .E(E), .busy(busy), .done(done), .s(s), .cout(cout),
        .ovf(ovf), .zero(zero)
    );

    serial_addsub_unit #(.WIDTH(16), .CHUNK(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start2), .a(a), .b(b), .sub(sub),
        .cin(cin), .E(E), .busy(busy2), .done(done2), .s(s2), .cout(cout2),
        .ovf(ovf2), .zero(zero2)
    );

    typedef struct {
        logic [15:0] r;
        logic        co;
        logic        ov;
        logic        z;
    } exp_t;

    int   n_checks = 0;
    int   n_err    = 0;
    bit   chk_en   = 1'b0;
    exp_t q[$];
    exp_t last;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Integer-arithmetic reference: unsigned range gives cout, signed range gives ovf.
    function automatic exp_t model(input logic [15:0] x, input logic [15:0] y,
                                   input logic sb, input logic ci);
        exp_t e;
        int   ux, uy, sx, sy, c, u, sg;
        ux = int'({16'd0, x});
        uy = int'({16'd0, y});
        sx = int'($signed(x));
        sy = int'($signed(y));
        c  = ci ? 1 : 0;
        if (!sb) begin
            u    = ux + uy + c;
            sg   = sx + sy + c;
            e.co = (u > 65535);
        end else begin
            u    = ux - uy - c;
            sg   = sx - sy - c;
            e.co = (u >= 0);
        end
        e.r  = u[15:0];
        e.ov = (sg > 32767) || (sg < -32768);
        e.z  = (e.r == 16'h0000);
        return e;
    endfunction

    // Scoreboard compare: results on done, held values otherwise.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy_done_excl", {31'd0, busy & done}, 32'd0);
            if (done) begin
                if (q.size() == 0) begin
                    chk("done_unexpected", {31'd0, done}, 32'd0);
                end else begin
                    last = q.pop_front();
                    chk("s_done", {16'd0, s}, {16'd0, last.r & {16{E}}});
                    chk("cout_done", {31'd0, cout}, {31'd0, last.co});
                    chk("ovf_done", {31'd0, ovf}, {31'd0, last.ov});
                    chk("zero_done", {31'd0, zero}, {31'd0, last.z});
                end
            end else begin
                chk("cout_hold", {31'd0, cout}, {31'd0, last.co});
                chk("ovf_hold", {31'd0, ovf}, {31'd0, last.ov});
                chk("zero_hold", {31'd0, zero}, {31'd0, last.z});
                if (!busy) chk("s_hold", {16'd0, s}, {16'd0, last.r & {16{E}}});
            end
        end
    end

    // Drive one accepted start; returns one edge after acceptance.
    task automatic issue(input logic [15:0] ia, input logic [15:0] ib,
                         input logic isub, input logic icin);
        a     = ia;
        b     = ib;
        sub   = isub;
        cin   = icin;
        start = 1'b1;
        q.push_back(model(ia, ib, isub, icin));
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
    endtask

    // Bounded wait for done; cyc counts edges waited (20 means timeout).
    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
            if (!done && cyc < 20) chk("busy_run", {31'd0, busy}, 32'd1);
        end while (!done && cyc < 20);
    endtask

    initial begin
        int c;
        rst_n  = 1'b0;
        start  = 1'b0;
        start2 = 1'b0;
        a      = 16'h0;
        b      = 16'h0;
        sub    = 1'b0;
        cin    = 1'b0;
        E      = 1'b1;
        last   = '{r: 16'h0, co: 1'b0, ov: 1'b0, z: 1'b0};
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_s", {16'd0, s}, 32'd0);
        chk("rst_flags", {29'd0, cout, ovf, zero}, 32'd0);
        chk_en = 1'b1;

        // Case 1: plain add, latency N=4.
        issue(16'h1234, 16'h4321, 1'b0, 1'b0);
        chk("c1_done_early", {31'd0, done}, 32'd0);
        wait_done(c);
        chk("c1_latency", c, 4);
        chk("c1_s", {16'd0, s}, 32'h5555);
        chk("c1_flags", {29'd0, cout, ovf, zero}, 32'd0);
        @(posedge clk); #1;
        chk("c1_done_pulse", {31'd0, done}, 32'd0);

        // Case 2: wrap to zero, then signed overflow.
        issue(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        wait_done(c);
        chk("c2a_s", {16'd0, s}, 32'h0000);
        chk("c2a_flags", {29'd0, cout, ovf, zero}, 32'b101);
        issue(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        wait_done(c);
        chk("c2b_s", {16'd0, s}, 32'h8000);
        chk("c2b_flags", {29'd0, cout, ovf, zero}, 32'b010);

        // Case 3: subtract variants.
        issue(16'h8000, 16'h0001, 1'b1, 1'b0);
        wait_done(c);
        chk("c3a_s", {16'd0, s}, 32'h7FFF);
        chk("c3a_flags", {29'd0, cout, ovf, zero}, 32'b110);
        issue(16'h0005, 16'h0003, 1'b1, 1'b1);
        wait_done(c);
        chk("c3b_s", {16'd0, s}, 32'h0001);
        chk("c3b_cout", {31'd0, cout}, 32'd1);
        issue(16'h0003, 16'h0005, 1'b1, 1'b0);
        wait_done(c);
        chk("c3c_s", {16'd0, s}, 32'hFFFE);
        chk("c3c_cout", {31'd0, cout}, 32'd0);
        @(posedge clk); #1;

        // Case 4: enable low throughout, raised after done.
        E = 1'b0;
        issue(16'h1234, 16'h4321, 1'b0, 1'b0);
        wait_done(c);
        chk("c4_done", {31'd0, done}, 32'd1);
        chk("c4_s_gated", {16'd0, s}, 32'h0000);
        chk("c4_flags", {29'd0, cout, ovf, zero}, 32'd0);
        E = 1'b1;
        #1;
        chk("c4_s_enabled", {16'd0, s}, 32'h5555);
        @(posedge clk); #1;

        // Case 5: start during RUN ignored, then start held in DONE.
        issue(16'h1234, 16'h4321, 1'b0, 1'b0);
        a     = 16'hAAAA;
        b     = 16'h1111;
        sub   = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(c);
        chk("c5_latency", c + 1, 4);
        chk("c5_s", {16'd0, s}, 32'h5555);
        issue(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        wait_done(c);
        chk("c5_b2b_gap", c + 1, 5);
        chk("c5_b2b_s", {16'd0, s}, 32'h0000);
        chk("c5_b2b_flags", {29'd0, cout, ovf, zero}, 32'b101);

        // Case 6: reset after chunk 2 aborts the operation.
        issue(16'h1234, 16'h4321, 1'b0, 1'b0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        q.delete();
        last = '{r: 16'h0, co: 1'b0, ov: 1'b0, z: 1'b0};
        chk("c6_busy", {31'd0, busy}, 32'd0);
        chk("c6_done", {31'd0, done}, 32'd0);
        chk("c6_s", {16'd0, s}, 32'd0);
        chk("c6_flags", {29'd0, cout, ovf, zero}, 32'd0);
        repeat (8) begin
            @(posedge clk); #1;
            chk("c6_no_done", {31'd0, done}, 32'd0);
        end
        issue(16'h1234, 16'h4321, 1'b0, 1'b0);
        wait_done(c);
        chk("c6_recover_s", {16'd0, s}, 32'h5555);

        // CHUNK == WIDTH: single RUN cycle.
        @(posedge clk); #1;
        a      = 16'h1234;
        b      = 16'h4321;
        sub    = 1'b0;
        cin    = 1'b0;
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        chk("w16_busy", {31'd0, busy2}, 32'd1);
        chk("w16_done_early", {31'd0, done2}, 32'd0);
        @(posedge clk); #1;
        chk("w16_done", {31'd0, done2}, 32'd1);
        chk("w16_s", {16'd0, s2}, 32'h5555);
        chk("w16_flags", {29'd0, cout2, ovf2, zero2}, 32'd0);
        @(posedge clk); #1;
        chk("w16_done_pulse", {31'd0, done2}, 32'd0);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/serial_addsub_unit.md
Name: serial_addsub_unit

Overview:
Parametrised, multi-cycle add/subtract unit that generalises the team's 4-bit gated ripple adder. It processes CHUNK bits per clock, LSB chunk first, and carries between chunks in a register. It adds subtract mode, carry-in, a start/busy/done handshake and status flags. As before, the sum output is gated by an enable. It sits in the ALU datapath where area matters more than single-cycle latency.

Parameters:
WIDTH, 16, operand/result width in bits
CHUNK, 4, bits processed per cycle; WIDTH % CHUNK must be 0 (elaboration error otherwise); N = WIDTH/CHUNK cycles per operation

Ports:
clk    input   1      single clock, rising-edge
rst_n  input   1      synchronous active-low reset
start  input   1      request operation; sampled only in IDLE or DONE
a      input   WIDTH  operand A, latched on accepted start
b      input   WIDTH  operand B, latched on accepted start
sub    input   1      0: a+b+cin; 1: a-b-cin; latched on start
cin    input   1      carry/borrow in, latched on start
E      input   1      output enable; combinational gate on s only
busy   output  1      operation in progress
done   output  1      one-cycle pulse, result valid
s      output  WIDTH  result AND E (all bits)
cout   output  1      carry out of MSB (sub: 1 = no borrow)
ovf    output  1      signed overflow
zero   output  1      ungated result == 0

Behaviour:
- Reset: synchronous, active-low; any state -> IDLE at the next edge with rst_n=0. busy=0, done=0, result reg=0 (s=0), cout=0, ovf=0, zero=0. A reset mid-operation aborts it; no partial result is visible.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 at an edge -> latch a, b^{WIDTH{sub}}, carry=cin^sub; chunk index k=0; go to RUN.
  - RUN: each edge computes chunk k as A[k]+B'[k]+carry (CHUNK-bit add). The sum chunk is written into the result reg and carry is updated; k increments. At the edge that processes k=N-1, go to DONE and register cout, ovf, zero.
  - DONE: lasts one cycle. start=1 -> accepted exactly as in IDLE (back-to-back), else -> IDLE.
- Timing: start accepted at edge 0 -> busy=1 from edge 0 to edge N -> done=1 from edge N to edge N+1. Latency is N cycles, and a new start can be accepted every N+1 cycles.
- busy=1 only in RUN. done=1 only in DONE.
- start while busy is ignored. Operand or mode changes during RUN have no effect.
- Result register, cout, ovf and zero hold their values from done until the next accepted start's first RUN edge. From that edge the result reg is overwritten chunk by chunk, and the flags hold their old values until the new done.
- ovf = carry into MSB XOR carry out of MSB (two's complement).
- zero is computed on the full registered result, independent of E.
- s = result & {WIDTH{E}}, combinational; toggling E affects s in the same cycle. cout, ovf and zero are not gated.
- CHUNK == WIDTH is legal (N=1): single RUN cycle.
- Intermediate result bits are visible on s during RUN when E=1. Consumers must qualify s with done.

Test Plan:
1. WIDTH=16, CHUNK=4, E=1: a=0x1234, b=0x4321, sub=0, cin=0, start at edge 0 -> busy=1 edges 0..4, done=1 after edge 4 only, s=0x5555, cout=0, ovf=0, zero=0.
2. a=0xFFFF, b=0x0001, sub=0 -> s=0x0000, cout=1, zero=1, ovf=0. Then a=0x7FFF, b=0x0001 -> s=0x8000, cout=0, ovf=1.
3. sub=1: a=0x8000, b=0x0001, cin=0 -> s=0x7FFF, cout=1, ovf=1. a=0x0005, b=0x0003, cin=1 -> s=0x0001, cout=1. a=0x0003, b=0x0005, cin=0 -> s=0xFFFE, cout=0.
4. E=0 throughout case 1 -> s=0x0000, done pulses, cout/ovf/zero as in case 1. Raise E after done -> s=0x5555 in the same cycle.
5. start pulsed during RUN with different operands -> ignored, case 1 result unchanged. start held high in the DONE cycle -> new operation begins, done pulses again 5 cycles after the first done.
6. rst_n=0 for one edge after chunk 2 of an operation -> busy=0, done=0, s=0, cout=0, ovf=0, zero=0 after that edge, and no done pulse follows. Repeat case 1 with CHUNK=16 -> done one cycle after start, same result.
